// File: rtl/mips_defs.sv
// Shared MIPS-lite encodings: opcodes, functs, datapath select codes,
// controller state encoding and the decoded instruction-class record.
package mips_defs;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b011;
    localparam logic [2:0] ALU_LUI  = 3'b111;

    localparam logic [1:0] PCS_PC4  = 2'b00;
    localparam logic [1:0] PCS_BR   = 2'b01;
    localparam logic [1:0] PCS_JMP  = 2'b10;
    localparam logic [1:0] PCS_RS   = 2'b11;

    localparam logic [1:0] RD_RT    = 2'b00;
    localparam logic [1:0] RD_RD    = 2'b01;
    localparam logic [1:0] RD_RA    = 2'b10;

    localparam logic [1:0] M2R_ALU  = 2'b00;
    localparam logic [1:0] M2R_LUI  = 2'b01;
    localparam logic [1:0] M2R_MDR  = 2'b10;
    localparam logic [1:0] M2R_PC   = 2'b11;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd7
    } state_t;

    typedef struct packed {
        logic addu;
        logic subu;
        logic ori;
        logic lui;
        logic lw;
        logic sw;
        logic beq;
        logic j;
        logic jal;
        logic jr;
        logic ill;
    } insn_t;

    // A zero timeout still needs a 1-bit counter to keep declarations legal.
    function automatic int unsigned cnt_width(input int unsigned t);
        return (t == 0) ? 1 : $clog2(t + 1);
    endfunction

endpackage

// File: rtl/insn_decode.sv
// Combinational Op/Func decode into a one-hot instruction class.
module insn_decode
    import mips_defs::*;
(
    input  logic [5:0] op_i,
    input  logic [5:0] func_i,
    output insn_t      insn_o
);

    always_comb begin
        insn_o = '0;
        case (op_i)
            OP_RTYPE: begin
                case (func_i)
                    FN_ADDU: insn_o.addu = 1'b1;
                    FN_SUBU: insn_o.subu = 1'b1;
                    FN_JR:   insn_o.jr   = 1'b1;
                    default: insn_o.ill  = 1'b1;
                endcase
            end
            OP_ORI:  insn_o.ori = 1'b1;
            OP_LUI:  insn_o.lui = 1'b1;
            OP_LW:   insn_o.lw  = 1'b1;
            OP_SW:   insn_o.sw  = 1'b1;
            OP_BEQ:  insn_o.beq = 1'b1;
            OP_J:    insn_o.j   = 1'b1;
            OP_JAL:  insn_o.jal = 1'b1;
            default: insn_o.ill = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle MIPS-lite control FSM: sequences fetch/decode/exec/mem/wb,
// waits on mem_ready with a timeout, and keeps sticky illegal/bus_err flags.
module mc_controller
    import mips_defs::*;
#(
    parameter int unsigned TIMEOUT_CYC = 15
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] Op,
    input  logic [5:0] Func,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       IMemReq,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic [1:0] PCSrc,
    output logic       RegWrite,
    output logic [1:0] RegDst,
    output logic [1:0] MemToReg,
    output logic       ALUSrc,
    output logic       ExtOp,
    output logic [2:0] ALUCtrl,
    output logic [2:0] state,
    output logic       illegal,
    output logic       bus_err
);

    localparam int unsigned    CW     = cnt_width(TIMEOUT_CYC);
    localparam logic [CW-1:0]  TO_LIM = CW'(TIMEOUT_CYC);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            illegal_q, illegal_d;
    logic            bus_err_q, bus_err_d;
    logic            wait_to;
    logic            waiting;
    insn_t           insn;

    insn_decode u_dec (
        .op_i   (Op),
        .func_i (Func),
        .insn_o (insn)
    );

    assign wait_to = (TIMEOUT_CYC != 0) && (cnt_q == TO_LIM) && !mem_ready;

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        IMemReq   = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        PCSrc     = PCS_PC4;
        RegWrite  = 1'b0;
        RegDst    = RD_RT;
        MemToReg  = M2R_ALU;
        ALUSrc    = 1'b0;
        ExtOp     = 1'b0;
        ALUCtrl   = 3'b000;

        case (state_q)
            ST_FETCH: begin
                IMemReq = 1'b1;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = ST_DECODE;
                end else if (wait_to) begin
                    bus_err_d = 1'b1;
                    state_d   = ST_HALT;
                end
            end
            ST_DECODE: begin
                if (insn.ill) begin
                    illegal_d = 1'b1;
                    state_d   = ST_HALT;
                end else if (insn.j) begin
                    PCWrite = 1'b1;
                    PCSrc   = PCS_JMP;
                    state_d = ST_FETCH;
                end else if (insn.jal) begin
                    RegWrite = 1'b1;
                    RegDst   = RD_RA;
                    MemToReg = M2R_PC;
                    PCWrite  = 1'b1;
                    PCSrc    = PCS_JMP;
                    state_d  = ST_FETCH;
                end else if (insn.jr) begin
                    PCWrite = 1'b1;
                    PCSrc   = PCS_RS;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                ALUSrc = insn.lw | insn.sw | insn.ori | insn.lui;
                ExtOp  = insn.ori;
                if (insn.addu || insn.lw || insn.sw) ALUCtrl = ALU_ADD;
                else if (insn.subu || insn.beq)      ALUCtrl = ALU_SUB;
                else if (insn.ori)                   ALUCtrl = ALU_OR;
                else if (insn.lui)                   ALUCtrl = ALU_LUI;
                if (insn.beq) begin
                    PCWrite = Zero;
                    PCSrc   = Zero ? PCS_BR : PCS_PC4;
                    state_d = ST_FETCH;
                end else if (insn.lw || insn.sw) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                MemRead  = insn.lw;
                MemWrite = insn.sw;
                if (mem_ready) begin
                    state_d = insn.lw ? ST_WB : ST_FETCH;
                end else if (wait_to) begin
                    bus_err_d = 1'b1;
                    state_d   = ST_HALT;
                end
            end
            ST_WB: begin
                RegWrite = 1'b1;
                RegDst   = (insn.addu || insn.subu) ? RD_RD : RD_RT;
                MemToReg = insn.lui ? M2R_LUI : (insn.lw ? M2R_MDR : M2R_ALU);
                state_d  = ST_FETCH;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_HALT;
        endcase

        // Reset overrides everything so no request leaks out during the reset cycle.
        if (!reset_n) begin
            IMemReq  = 1'b0;
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            IRWrite  = 1'b0;
            PCWrite  = 1'b0;
            PCSrc    = PCS_PC4;
            RegWrite = 1'b0;
            RegDst   = RD_RT;
            MemToReg = M2R_ALU;
            ALUSrc   = 1'b0;
            ExtOp    = 1'b0;
            ALUCtrl  = 3'b000;
        end
    end

    // Counter only runs while a request is outstanding and unchanged; any
    // completion, state change or fault returns it to zero.
    assign waiting = (state_q == ST_FETCH || state_q == ST_MEM) &&
                     (state_d == state_q) && !mem_ready && (TIMEOUT_CYC != 0);
    assign cnt_d   = waiting ? cnt_q + 1'b1 : '0;

    assign state   = reset_n ? state_q : 3'b000;
    assign illegal = reset_n & illegal_q;
    assign bus_err = reset_n & bus_err_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_FETCH;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: per-cycle expected output vectors are
// queued as stimulus is driven and compared at the following falling edge.
module tb_mc_controller;

    localparam logic [5:0] T_RTYPE = 6'h00, T_J = 6'h02, T_JAL = 6'h03, T_BEQ = 6'h04;
    localparam logic [5:0] T_ORI = 6'h0D, T_LUI = 6'h0F, T_LW = 6'h23, T_SW = 6'h2B;
    localparam logic [5:0] T_ADDU = 6'h21, T_SUBU = 6'h23, T_JR = 6'h08;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [5:0] Op = '0;
    logic [5:0] Func = '0;
    logic       Zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       IMemReq, MemRead, MemWrite, IRWrite, PCWrite, RegWrite;
    logic       ALUSrc, ExtOp, illegal, bus_err;
    logic [1:0] PCSrc, RegDst, MemToReg;
    logic [2:0] ALUCtrl, state;

    mc_controller #(.TIMEOUT_CYC(15)) dut (
        .clk(clk), .reset_n(reset_n), .Op(Op), .Func(Func), .Zero(Zero),
        .mem_ready(mem_ready), .IMemReq(IMemReq), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .PCSrc(PCSrc), .RegWrite(RegWrite), .RegDst(RegDst),
        .MemToReg(MemToReg), .ALUSrc(ALUSrc), .ExtOp(ExtOp),
        .ALUCtrl(ALUCtrl), .state(state), .illegal(illegal), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    // {state, IMemReq, MemRead, MemWrite, IRWrite, PCWrite, RegWrite,
    //  PCSrc, RegDst, MemToReg, ALUSrc, ExtOp, ALUCtrl, illegal, bus_err}
    logic [21:0] obs;
    assign obs = {state, IMemReq, MemRead, MemWrite, IRWrite, PCWrite, RegWrite,
                  PCSrc, RegDst, MemToReg, ALUSrc, ExtOp, ALUCtrl, illegal, bus_err};

    typedef struct {
        logic        rst_n;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        rdy;
        logic [21:0] exp;
    } step_t;

    step_t       steps[$];
    logic [21:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;

    function automatic logic [21:0] mk(input logic [2:0] st, input logic [5:0] en,
                                       input logic [1:0] pcs, input logic [1:0] rdst,
                                       input logic [1:0] m2r, input logic als,
                                       input logic ext, input logic [2:0] alu,
                                       input logic ill, input logic berr);
        return {st, en, pcs, rdst, m2r, als, ext, alu, ill, berr};
    endfunction

    // en = {IMemReq, MemRead, MemWrite, IRWrite, PCWrite, RegWrite}
    logic [21:0] E_RST, E_FWAIT, E_FGO, E_DEC, E_HALT_BUS, E_HALT_ILL;
    initial begin
        E_RST      = '0;
        E_FWAIT    = mk(3'd0, 6'b100000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
        E_FGO      = mk(3'd0, 6'b100110, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
        E_DEC      = mk(3'd1, 6'b000000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
        E_HALT_BUS = mk(3'd7, 6'b000000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1);
        E_HALT_ILL = mk(3'd7, 6'b000000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0);
    end

    task automatic add(input logic r, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic rdy, input logic [21:0] e);
        step_t s;
        s.rst_n = r; s.op = op; s.fn = fn; s.z = z; s.rdy = rdy; s.exp = e;
        steps.push_back(s);
    endtask

    task automatic test_reset();
        logic [21:0] got, e;
        steps.delete();
        add(1'b0, T_LW, 6'h00, 1'b0, 1'b1, E_RST);
        add(1'b0, T_RTYPE, T_ADDU, 1'b1, 1'b0, E_RST);
        add(1'b1, T_RTYPE, T_ADDU, 1'b0, 1'b0, E_FWAIT);
        for (int i = 0; i < steps.size(); i++) begin
            reset_n = steps[i].rst_n; Op = steps[i].op; Func = steps[i].fn;
            Zero = steps[i].z; mem_ready = steps[i].rdy;
            exp_q.push_back(steps[i].exp);
            @(negedge clk);
            got = obs; e = exp_q.pop_front(); checks++;
            if (got !== e) begin errors++; $display("FAIL reset step %0d got %h exp %h", i, got, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_addu();
        logic [21:0] got, e;
        steps.delete();
        add(1'b0, T_RTYPE, T_ADDU, 1'b0, 1'b0, E_RST);
        add(1'b1, T_RTYPE, T_ADDU, 1'b0, 1'b1, E_FGO);
        add(1'b1, T_RTYPE, T_ADDU, 1'b0, 1'b0, E_DEC);
        add(1'b1, T_RTYPE, T_ADDU, 1'b0, 1'b0, mk(3'd2, 6'b000000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0));
        add(1'b1, T_RTYPE, T_ADDU, 1'b0, 1'b0, mk(3'd4, 6'b000001, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0));
        add(1'b1, T_RTYPE, T_ADDU, 1'b0, 1'b0, E_FWAIT);
        for (int i = 0; i < steps.size(); i++) begin
            reset_n = steps[i].rst_n; Op = steps[i].op; Func = steps[i].fn;
            Zero = steps[i].z; mem_ready = steps[i].rdy;
            exp_q.push_back(steps[i].exp);
            @(negedge clk);
            got = obs; e = exp_q.pop_front(); checks++;
            if (got !== e) begin errors++; $display("FAIL addu step %0d got %h exp %h", i, got, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_lw_wait();
        logic [21:0] got, e;
        logic [21:0] mem_rd;
        mem_rd = mk(3'd3, 6'b010000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
        steps.delete();
        add(1'b0, T_LW, 6'h05, 1'b0, 1'b0, E_RST);
        add(1'b1, T_LW, 6'h05, 1'b0, 1'b1, E_FGO);
        add(1'b1, T_LW, 6'h05, 1'b0, 1'b0, E_DEC);
        add(1'b1, T_LW, 6'h05, 1'b0, 1'b0, mk(3'd2, 6'b000000, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 3'b010, 1'b0, 1'b0));
        for (int k = 0; k < 3; k++) add(1'b1, T_LW, 6'h05, 1'b0, 1'b0, mem_rd);
        add(1'b1, T_LW, 6'h05, 1'b0, 1'b1, mem_rd);
        add(1'b1, T_LW, 6'h05, 1'b0, 1'b0, mk(3'd4, 6'b000001, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0));
        add(1'b1, T_LW, 6'h05, 1'b0, 1'b0, E_FWAIT);
        for (int i = 0; i < steps.size(); i++) begin
            reset_n = steps[i].rst_n; Op = steps[i].op; Func = steps[i].fn;
            Zero = steps[i].z; mem_ready = steps[i].rdy;
            exp_q.push_back(steps[i].exp);
            @(negedge clk);
            got = obs; e = exp_q.pop_front(); checks++;
            if (got !== e) begin errors++; $display("FAIL lw_wait step %0d got %h exp %h", i, got, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_beq();
        logic [21:0] got, e;
        steps.delete();
        add(1'b0, T_BEQ, 6'h00, 1'b0, 1'b0, E_RST);
        add(1'b1, T_BEQ, 6'h00, 1'b1, 1'b1, E_FGO);
        add(1'b1, T_BEQ, 6'h00, 1'b1, 1'b0, E_DEC);
        add(1'b1, T_BEQ, 6'h00, 1'b1, 1'b0, mk(3'd2, 6'b000010, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 3'b011, 1'b0, 1'b0));
        add(1'b1, T_BEQ, 6'h00, 1'b0, 1'b1, E_FGO);
        add(1'b1, T_BEQ, 6'h00, 1'b0, 1'b0, E_DEC);
        add(1'b1, T_BEQ, 6'h00, 1'b0, 1'b0, mk(3'd2, 6'b000000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 3'b011, 1'b0, 1'b0));
        add(1'b1, T_BEQ, 6'h00, 1'b0, 1'b0, E_FWAIT);
        for (int i = 0; i < steps.size(); i++) begin
            reset_n = steps[i].rst_n; Op = steps[i].op; Func = steps[i].fn;
            Zero = steps[i].z; mem_ready = steps[i].rdy;
            exp_q.push_back(steps[i].exp);
            @(negedge clk);
            got = obs; e = exp_q.pop_front(); checks++;
            if (got !== e) begin errors++; $display("FAIL beq step %0d got %h exp %h", i, got, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_jumps();
        logic [21:0] got, e;
        steps.delete();
        add(1'b0, T_JAL, 6'h00, 1'b0, 1'b0, E_RST);
        add(1'b1, T_JAL, 6'h00, 1'b0, 1'b1, E_FGO);
        add(1'b1, T_JAL, 6'h00, 1'b0, 1'b0, mk(3'd1, 6'b000011, 2'b10, 2'b10, 2'b11, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0));
        add(1'b1, T_J, 6'h00, 1'b0, 1'b1, E_FGO);
        add(1'b1, T_J, 6'h00, 1'b0, 1'b0, mk(3'd1, 6'b000010, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0));
        add(1'b1, T_RTYPE, T_JR, 1'b0, 1'b1, E_FGO);
        add(1'b1, T_RTYPE, T_JR, 1'b0, 1'b0, mk(3'd1, 6'b000010, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0));
        add(1'b1, T_RTYPE, T_JR, 1'b0, 1'b0, E_FWAIT);
        for (int i = 0; i < steps.size(); i++) begin
            reset_n = steps[i].rst_n; Op = steps[i].op; Func = steps[i].fn;
            Zero = steps[i].z; mem_ready = steps[i].rdy;
            exp_q.push_back(steps[i].exp);
            @(negedge clk);
            got = obs; e = exp_q.pop_front(); checks++;
            if (got !== e) begin errors++; $display("FAIL jumps step %0d got %h exp %h", i, got, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [21:0] got, e;
        steps.delete();
        add(1'b0, T_ORI, 6'h00, 1'b0, 1'b0, E_RST);
        add(1'b1, T_ORI, 6'h00, 1'b0, 1'b1, E_FGO);
        add(1'b1, T_ORI, 6'h00, 1'b0, 1'b0, E_DEC);
        add(1'b1, T_ORI, 6'h00, 1'b0, 1'b0, mk(3'd2, 6'b000000, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 3'b001, 1'b0, 1'b0));
        add(1'b1, T_ORI, 6'h00, 1'b0, 1'b0, mk(3'd4, 6'b000001, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0));
        add(1'b1, T_LUI, 6'h00, 1'b0, 1'b1, E_FGO);
        add(1'b1, T_LUI, 6'h00, 1'b0, 1'b0, E_DEC);
        add(1'b1, T_LUI, 6'h00, 1'b0, 1'b0, mk(3'd2, 6'b000000, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 3'b111, 1'b0, 1'b0));
        add(1'b1, T_LUI, 6'h00, 1'b0, 1'b0, mk(3'd4, 6'b000001, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0));
        add(1'b1, T_SW, 6'h00, 1'b0, 1'b1, E_FGO);
        add(1'b1, T_SW, 6'h00, 1'b0, 1'b0, E_DEC);
        add(1'b1, T_SW, 6'h00, 1'b0, 1'b0, mk(3'd2, 6'b000000, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 3'b010, 1'b0, 1'b0));
        add(1'b1, T_SW, 6'h00, 1'b0, 1'b1, mk(3'd3, 6'b001000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0));
        add(1'b1, T_RTYPE, T_SUBU, 1'b0, 1'b1, E_FGO);
        add(1'b1, T_RTYPE, T_SUBU, 1'b0, 1'b0, E_DEC);
        add(1'b1, T_RTYPE, T_SUBU, 1'b0, 1'b0, mk(3'd2, 6'b000000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 3'b011, 1'b0, 1'b0));
        add(1'b1, T_RTYPE, T_SUBU, 1'b0, 1'b0, mk(3'd4, 6'b000001, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0));
        add(1'b1, T_RTYPE, T_SUBU, 1'b0, 1'b0, E_FWAIT);
        for (int i = 0; i < steps.size(); i++) begin
            reset_n = steps[i].rst_n; Op = steps[i].op; Func = steps[i].fn;
            Zero = steps[i].z; mem_ready = steps[i].rdy;
            exp_q.push_back(steps[i].exp);
            @(negedge clk);
            got = obs; e = exp_q.pop_front(); checks++;
            if (got !== e) begin errors++; $display("FAIL back_to_back step %0d got %h exp %h", i, got, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout();
        logic [21:0] got, e;
        steps.delete();
        add(1'b0, T_RTYPE, T_ADDU, 1'b0, 1'b0, E_RST);
        for (int k = 0; k < 16; k++) add(1'b1, T_RTYPE, T_ADDU, 1'b0, 1'b0, E_FWAIT);
        add(1'b1, T_RTYPE, T_ADDU, 1'b0, 1'b0, E_HALT_BUS);
        add(1'b1, T_RTYPE, T_ADDU, 1'b0, 1'b1, E_HALT_BUS);
        add(1'b1, T_RTYPE, T_ADDU, 1'b0, 1'b1, E_HALT_BUS);
        add(1'b0, T_RTYPE, T_ADDU, 1'b0, 1'b0, E_RST);
        // ready on the final permitted wait cycle completes the fetch
        for (int k = 0; k < 15; k++) add(1'b1, T_RTYPE, T_ADDU, 1'b0, 1'b0, E_FWAIT);
        add(1'b1, T_RTYPE, T_ADDU, 1'b0, 1'b1, E_FGO);
        add(1'b1, T_RTYPE, T_ADDU, 1'b0, 1'b0, E_DEC);
        for (int i = 0; i < steps.size(); i++) begin
            reset_n = steps[i].rst_n; Op = steps[i].op; Func = steps[i].fn;
            Zero = steps[i].z; mem_ready = steps[i].rdy;
            exp_q.push_back(steps[i].exp);
            @(negedge clk);
            got = obs; e = exp_q.pop_front(); checks++;
            if (got !== e) begin errors++; $display("FAIL timeout step %0d got %h exp %h", i, got, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_faults();
        logic [21:0] got, e;
        logic [21:0] mem_rd;
        mem_rd = mk(3'd3, 6'b010000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
        steps.delete();
        add(1'b0, T_RTYPE, 6'h00, 1'b0, 1'b0, E_RST);
        add(1'b1, T_RTYPE, 6'h00, 1'b0, 1'b1, E_FGO);
        add(1'b1, T_RTYPE, 6'h00, 1'b0, 1'b0, E_DEC);
        add(1'b1, T_RTYPE, 6'h00, 1'b0, 1'b1, E_HALT_ILL);
        add(1'b1, T_ADDU, 6'h00, 1'b0, 1'b1, E_HALT_ILL);
        add(1'b0, 6'h3F, 6'h00, 1'b0, 1'b0, E_RST);
        add(1'b1, 6'h3F, 6'h00, 1'b0, 1'b1, E_FGO);
        add(1'b1, 6'h3F, 6'h00, 1'b0, 1'b0, E_DEC);
        add(1'b1, 6'h3F, 6'h00, 1'b0, 1'b0, E_HALT_ILL);
        add(1'b0, T_LW, 6'h00, 1'b0, 1'b0, E_RST);
        add(1'b1, T_LW, 6'h00, 1'b0, 1'b1, E_FGO);
        add(1'b1, T_LW, 6'h00, 1'b0, 1'b0, E_DEC);
        add(1'b1, T_LW, 6'h00, 1'b0, 1'b0, mk(3'd2, 6'b000000, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 3'b010, 1'b0, 1'b0));
        add(1'b1, T_LW, 6'h00, 1'b0, 1'b0, mem_rd);
        add(1'b1, T_LW, 6'h00, 1'b0, 1'b0, mem_rd);
        add(1'b0, T_LW, 6'h00, 1'b0, 1'b1, E_RST);
        add(1'b1, T_LW, 6'h00, 1'b0, 1'b0, E_FWAIT);
        for (int i = 0; i < steps.size(); i++) begin
            reset_n = steps[i].rst_n; Op = steps[i].op; Func = steps[i].fn;
            Zero = steps[i].z; mem_ready = steps[i].rdy;
            exp_q.push_back(steps[i].exp);
            @(negedge clk);
            got = obs; e = exp_q.pop_front(); checks++;
            if (got !== e) begin errors++; $display("FAIL faults step %0d got %h exp %h", i, got, e); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_addu();
        test_lw_wait();
        test_beq();
        test_jumps();
        test_back_to_back();
        test_timeout();
        test_faults();
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left %0d required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
